// File: rtl/rotseq_pkg.sv
// Shared types and latency constants for rotate_sequencer.
package rotseq_pkg;

  localparam int MEM_LAT  = 1;
  localparam int ROT_LAT  = 2;
  localparam int PIPE_LEN = MEM_LAT + ROT_LAT;
  localparam int RES_W    = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic signed [RES_W-1:0] x;
    logic signed [RES_W-1:0] y;
    logic                    last;
  } rot_result_t;

  // Clamp a rotator result into the s4.0 range [-16, 15].
  function automatic logic signed [RES_W-1:0] sat_s4(input logic signed [RES_W-1:0] v);
    if (v > 6'sd15) begin
      return 6'sd15;
    end else if (v < -6'sd16) begin
      return -6'sd16;
    end
    return v;
  endfunction

endpackage

// File: rtl/rotseq_fifo.sv
// Synchronous result FIFO, parameterised on depth and payload type.
// Read data is forced to zero while empty so idle outputs are deterministic.
module rotseq_fifo #(
  parameter int DEPTH = 4,
  parameter type T    = logic [7:0]
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  T                           wdata_i,
  input  logic                       pop_i,
  output T                           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // A push into a full FIFO is only accepted when a pop frees the slot.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/rotate_sequencer.sv
// Job controller streaming points through the external two-stage rotator into a result FIFO.
// Optional ROTSEQ_SAT_EN clamps results to s4.0 before they enter the FIFO.
//   state | meaning
//   IDLE  | waiting for a job, job_ready high
//   ISSUE | issuing point reads whenever FIFO credit allows
//   DRAIN | all reads issued, waiting for pipeline and FIFO to empty
//   DONE  | one-cycle completion pulse
module rotate_sequencer
  import rotseq_pkg::*;
#(
  parameter int COUNT_W    = 8,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                job_valid,
  output logic                job_ready,
  input  logic [ADDR_W-1:0]   job_base,
  input  logic [COUNT_W-1:0]  job_count,
  input  logic signed [8:0]   job_cos,
  input  logic signed [8:0]   job_sin,
  output logic                pt_rd,
  output logic [ADDR_W-1:0]   pt_addr,
  input  logic signed [4:0]   pt_x,
  input  logic signed [4:0]   pt_y,
  output logic signed [4:0]   rot_ix,
  output logic signed [4:0]   rot_iy,
  output logic signed [8:0]   rot_cos,
  output logic signed [8:0]   rot_sin,
  input  logic signed [5:0]   rot_ox,
  input  logic signed [5:0]   rot_oy,
  output logic                res_valid,
  input  logic                res_ready,
  output logic signed [5:0]   res_x,
  output logic signed [5:0]   res_y,
  output logic                res_last,
  output logic                busy,
  output logic                done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W = $clog2(PIPE_LEN + 1);
  localparam int OCC_W = $clog2(FIFO_DEPTH + PIPE_LEN + 1) + 1;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [COUNT_W-1:0]   remain_q, remain_d;
  logic signed [8:0]    cos_q, cos_d;
  logic signed [8:0]    sin_q, sin_d;
  logic [PIPE_LEN-1:0]  valid_q;
  logic [PIPE_LEN-1:0]  last_q;

  logic                 issue_last;
  logic [INF_W-1:0]     inflight;
  logic [OCC_W-1:0]     occupancy;
  logic                 credit_ok;

  rot_result_t          push_data;
  rot_result_t          pop_data;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < PIPE_LEN; i++) begin
      inflight = inflight + INF_W'(valid_q[i]);
    end
  end

  // Every issued read owns a FIFO slot from issue until it is popped, so the
  // rotator never has to stall.
  assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight) - OCC_W'(fifo_pop);
  assign credit_ok = (occupancy < OCC_W'(FIFO_DEPTH));

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    cos_d      = cos_q;
    sin_d      = sin_q;
    job_ready  = 1'b0;
    pt_rd      = 1'b0;
    issue_last = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        job_ready = 1'b1;
        if (job_valid) begin
          addr_d   = job_base;
          remain_d = job_count;
          cos_d    = job_cos;
          sin_d    = job_sin;
          state_d  = (job_count == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (credit_ok) begin
          pt_rd      = 1'b1;
          issue_last = (remain_q == COUNT_W'(1));
          addr_d     = addr_q + ADDR_W'(1);
          remain_d   = remain_q - COUNT_W'(1);
          if (issue_last) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if ((inflight == '0) && fifo_empty) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      cos_q    <= '0;
      sin_q    <= '0;
      valid_q  <= '0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      cos_q    <= cos_d;
      sin_q    <= sin_d;
      valid_q  <= {valid_q[PIPE_LEN-2:0], pt_rd};
      last_q   <= {last_q[PIPE_LEN-2:0], issue_last};
    end
  end

`ifdef ROTSEQ_SAT_EN
  assign push_data.x = sat_s4(rot_ox);
  assign push_data.y = sat_s4(rot_oy);
`else
  assign push_data.x = rot_ox;
  assign push_data.y = rot_oy;
`endif
  assign push_data.last = last_q[PIPE_LEN-1];
  assign fifo_push      = valid_q[PIPE_LEN-1];
  assign fifo_pop       = res_ready && !fifo_empty;

  rotseq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (rot_result_t)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (fifo_push),
    .wdata_i (push_data),
    .pop_i   (fifo_pop),
    .rdata_o (pop_data),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign pt_addr   = addr_q;
  assign rot_ix    = pt_x;
  assign rot_iy    = pt_y;
  assign rot_cos   = cos_q;
  assign rot_sin   = sin_q;
  assign res_valid = !fifo_empty;
  assign res_x     = pop_data.x;
  assign res_y     = pop_data.y;
  assign res_last  = pop_data.last;
  assign busy      = (state_q != ST_IDLE);

  assert property (@(posedge clk) disable iff (rst) (fifo_push && fifo_full) |-> fifo_pop);

endmodule

// File: tb/tb_rotate_sequencer.sv
// Scoreboard bench for rotate_sequencer with point memory and two-stage rotator models.
module tb_rotate_sequencer;

  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              job_valid;
  logic              job_ready;
  logic [7:0]        job_base;
  logic [7:0]        job_count;
  logic signed [8:0] job_cos;
  logic signed [8:0] job_sin;
  logic              pt_rd;
  logic [7:0]        pt_addr;
  logic signed [4:0] pt_x;
  logic signed [4:0] pt_y;
  logic signed [4:0] rot_ix;
  logic signed [4:0] rot_iy;
  logic signed [8:0] rot_cos;
  logic signed [8:0] rot_sin;
  logic signed [5:0] rot_ox;
  logic signed [5:0] rot_oy;
  logic              res_valid;
  logic              res_ready;
  logic signed [5:0] res_x;
  logic signed [5:0] res_y;
  logic              res_last;
  logic              busy;
  logic              done;

  rotate_sequencer #(.COUNT_W(8), .ADDR_W(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_base(job_base), .job_count(job_count), .job_cos(job_cos), .job_sin(job_sin),
    .pt_rd(pt_rd), .pt_addr(pt_addr), .pt_x(pt_x), .pt_y(pt_y),
    .rot_ix(rot_ix), .rot_iy(rot_iy), .rot_cos(rot_cos), .rot_sin(rot_sin),
    .rot_ox(rot_ox), .rot_oy(rot_oy), .res_valid(res_valid), .res_ready(res_ready),
    .res_x(res_x), .res_y(res_y), .res_last(res_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Point memory: one cycle read latency.
  logic signed [4:0] mem_x [256];
  logic signed [4:0] mem_y [256];
  always @(posedge clk) begin
    if (pt_rd) begin
      pt_x <= mem_x[pt_addr];
      pt_y <= mem_y[pt_addr];
    end
  end

  // Rotator model; the full-scale code 0x100 stands for +1.0.
  function automatic int coef(input logic [8:0] c);
    return (c == 9'h100) ? 256 : int'($signed(c));
  endfunction

  logic signed [5:0] s1x, s1y, s2x, s2y;
  always @(posedge clk) begin
    s1x <= 6'((int'(rot_ix) * coef(rot_cos) - int'(rot_iy) * coef(rot_sin)) >>> 8);
    s1y <= 6'((int'(rot_ix) * coef(rot_sin) + int'(rot_iy) * coef(rot_cos)) >>> 8);
    s2x <= s1x;
    s2y <= s1y;
  end
  assign rot_ox = s2x;
  assign rot_oy = s2y;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  typedef struct {
    int x;
    int y;
    int last;
  } exp_t;
  exp_t exp_q[$];

  task automatic expect_res(input int x, input int y, input int last);
    exp_t e;
    e.x = x;
    e.y = y;
    e.last = last;
    exp_q.push_back(e);
  endtask

  // Monitor: event logs by cycle, scoreboard compare on every pop.
  int rd_log[$], rd_addr_log[$], resv_log[$], done_log[$], acc_log[$], cfg_log[$];
  int outstanding = 0;
  int credit_viol = 0;
  int ready_viol = 0;
  int pop_cnt = 0;
  bit pop_now;
  exp_t mon_e;
  logic [17:0] prev_cfg = '0;

  always @(negedge clk) begin
    if (rst) begin
      outstanding = 0;
    end else begin
      pop_now = res_valid && res_ready;
      if (pt_rd) begin
        rd_log.push_back(cyc);
        rd_addr_log.push_back(int'(pt_addr));
        if (outstanding - int'(pop_now) >= DEPTH) credit_viol++;
      end
      if (res_valid) resv_log.push_back(cyc);
      if (pop_now) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got (%0d,%0d) with no expected entry", res_x, res_y);
        end else begin
          mon_e = exp_q.pop_front();
          check("res_x", int'(res_x), mon_e.x);
          check("res_y", int'(res_y), mon_e.y);
          check("res_last", int'(res_last), mon_e.last);
        end
      end
      outstanding += int'(pt_rd) - int'(pop_now);
      if (done) done_log.push_back(cyc);
      if (job_valid && job_ready) acc_log.push_back(cyc);
      if (busy && job_ready) ready_viol++;
    end
    if ({rot_cos, rot_sin} != prev_cfg) begin
      cfg_log.push_back(cyc);
      prev_cfg = {rot_cos, rot_sin};
    end
  end

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1000;
  endfunction

  bit tog_en = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
    if (tog_en) res_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
  endtask

  task automatic send_job(input int base, input int count, input int c, input int s, input bit hold);
    int a0;
    int n;
    a0 = acc_log.size();
    n = 0;
    job_base  = 8'(base);
    job_count = 8'(count);
    job_cos   = 9'(c);
    job_sin   = 9'(s);
    job_valid = 1'b1;
    while (acc_log.size() == a0 && n < 300) begin
      step();
      n++;
    end
    if (acc_log.size() == a0) bound_fail("job_accept");
    if (!hold) job_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_log.size() < target && n < budget) begin
      step();
      n++;
    end
    if (done_log.size() < target) bound_fail("job_done");
    repeat (3) step();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_job_ready"}, int'(job_ready), 1);
    check({tag, "_pt_rd"}, int'(pt_rd), 0);
    check({tag, "_pt_addr"}, int'(pt_addr), 0);
    check({tag, "_rot_cos"}, int'(rot_cos), 0);
    check({tag, "_rot_sin"}, int'(rot_sin), 0);
    check({tag, "_res_valid"}, int'(res_valid), 0);
    check({tag, "_res_x"}, int'(res_x), 0);
    check({tag, "_res_y"}, int'(res_y), 0);
    check({tag, "_res_last"}, int'(res_last), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rb, vb, db, ab, cb, pb;
    int n;
    rst = 1'b1;
    job_valid = 1'b0;
    job_base = '0;
    job_count = '0;
    job_cos = '0;
    job_sin = '0;
    res_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      mem_x[i] = '0;
      mem_y[i] = '0;
    end
    mem_x[8'h10] = 5'sd1;   mem_y[8'h10] = 5'sd2;
    mem_x[8'h11] = -5'sd3;  mem_y[8'h11] = 5'sd4;
    mem_x[8'h12] = 5'sd15;  mem_y[8'h12] = -5'sd16;
    mem_x[8'h20] = 5'sd5;   mem_y[8'h20] = -5'sd7;
    mem_x[8'h21] = -5'sd16; mem_y[8'h21] = -5'sd16;
    for (int i = 0; i < 20; i++) begin
      mem_x[8'h40 + i] = 5'(i - 10);
      mem_y[8'h40 + i] = 5'(7 - i);
    end
    for (int i = 0; i < 8; i++) begin
      mem_x[8'h60 + i] = 5'(i);
      mem_y[8'h60 + i] = 5'(-i);
    end

    repeat (3) step();
    rst = 1'b0;
    #1;
    check_reset_values("rst");

    // Identity job: three points, latency and back-to-back issue.
    rb = rd_log.size(); vb = resv_log.size(); db = done_log.size();
    expect_res(1, 2, 0);
    expect_res(-3, 4, 0);
    expect_res(15, -16, 1);
    send_job(8'h10, 3, 9'h100, 0, 1'b0);
    #1;
    check("j1_busy_after_accept", int'(busy), 1);
    check("j1_rot_cos_latched", int'($unsigned(rot_cos)), 256);
    wait_done(db + 1, 100);
    check("j1_reads", rd_log.size() - rb, 3);
    check("j1_first_addr", q_at(rd_addr_log, rb), 8'h10);
    check("j1_last_addr", q_at(rd_addr_log, rb + 2), 8'h12);
    check("j1_read_latency", q_at(resv_log, vb) - q_at(rd_log, rb), 4);
    check("j1_back_to_back", q_at(rd_log, rb + 2) - q_at(rd_log, rb), 2);
    check("j1_done_pulses", done_log.size() - db, 1);
    check("j1_busy_after_done", int'(busy), 0);
    check("j1_queue_drained", exp_q.size(), 0);

    // 90 degree rotation.
    rb = rd_log.size(); db = done_log.size();
    expect_res(7, 5, 0);
`ifdef ROTSEQ_SAT_EN
    expect_res(15, -16, 1);
`else
    expect_res(16, -16, 1);
`endif
    send_job(8'h20, 2, 0, 9'h100, 1'b0);
    wait_done(db + 1, 100);
    check("j2_reads", rd_log.size() - rb, 2);
    check("j2_queue_drained", exp_q.size(), 0);

    // 20 points under 1-0-0-1 backpressure.
    rb = rd_log.size(); db = done_log.size(); pb = pop_cnt;
    for (int i = 0; i < 20; i++) expect_res(i - 10, 7 - i, (i == 19) ? 1 : 0);
    tog_en = 1'b1;
    send_job(8'h40, 20, 9'h100, 0, 1'b0);
    wait_done(db + 1, 600);
    tog_en = 1'b0;
    res_ready = 1'b1;
    check("j3_reads", rd_log.size() - rb, 20);
    check("j3_results", pop_cnt - pb, 20);
    check("j3_read_stalled", int'(q_at(rd_log, rb + 19) - q_at(rd_log, rb) > 19), 1);
    check("j3_credit_violations", credit_viol, 0);
    check("j3_queue_drained", exp_q.size(), 0);

    // Zero-length job.
    rb = rd_log.size(); vb = resv_log.size(); db = done_log.size(); ab = acc_log.size();
    send_job(8'h70, 0, 9'h100, 0, 1'b0);
    wait_done(db + 1, 50);
    check("j4_no_reads", rd_log.size() - rb, 0);
    check("j4_no_results", resv_log.size() - vb, 0);
    check("j4_done_latency", q_at(done_log, db) - q_at(acc_log, ab), 1);

    // Reset two cycles after the third read of an 8-point job.
    res_ready = 1'b0;
    rb = rd_log.size();
    send_job(8'h60, 8, 9'h100, 0, 1'b0);
    n = 0;
    while (rd_log.size() - rb < 3 && n < 100) begin
      step();
      n++;
    end
    if (rd_log.size() - rb < 3) bound_fail("j5_third_read");
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_reset_values("midrst");
    res_ready = 1'b1;
    rb = rd_log.size(); vb = resv_log.size();
    repeat (10) step();
    check("j5_no_res_after_reset", resv_log.size() - vb, 0);
    check("j5_no_reads_after_reset", rd_log.size() - rb, 0);
    db = done_log.size();
    expect_res(1, 2, 0);
    expect_res(-3, 4, 0);
    expect_res(15, -16, 1);
    send_job(8'h10, 3, 9'h100, 0, 1'b0);
    wait_done(db + 1, 100);
    check("j5_rerun_reads", rd_log.size() - rb, 3);
    check("j5_queue_drained", exp_q.size(), 0);

    // job_valid held across two jobs.
    db = done_log.size(); ab = acc_log.size(); cb = cfg_log.size();
    expect_res(1, 2, 0);
    expect_res(-3, 4, 0);
    expect_res(15, -16, 1);
    expect_res(7, 5, 0);
`ifdef ROTSEQ_SAT_EN
    expect_res(15, -16, 1);
`else
    expect_res(16, -16, 1);
`endif
    send_job(8'h10, 3, 9'h100, 0, 1'b1);
    job_base = 8'h20;
    job_count = 8'd2;
    job_cos = 9'h000;
    job_sin = 9'h100;
    n = 0;
    while (acc_log.size() < ab + 2 && n < 200) begin
      step();
      n++;
    end
    if (acc_log.size() < ab + 2) bound_fail("j6_second_accept");
    job_valid = 1'b0;
    wait_done(db + 2, 200);
    check("j6_accepts", acc_log.size() - ab, 2);
    check("j6_second_after_done", q_at(acc_log, ab + 1) - q_at(done_log, db), 1);
    check("j6_cfg_changes", cfg_log.size() - cb, 1);
    check("j6_cfg_change_cycle", q_at(cfg_log, cb) - q_at(acc_log, ab + 1), 1);
    check("j6_queue_drained", exp_q.size(), 0);

    check("ready_while_busy", ready_viol, 0);
    check("credit_violations", credit_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
